fc64_seq_ctrl: RTL
==================

FC64_SEQ_CTRL -- requirements
Module: fc64_seq_ctrl

Interface
REQ-001 SHALL have parameter N_IN, default 64, meaning input-vector length per neuron (fixed 64).
REQ-002 SHALL have parameter N_OUT, default 10, meaning output-neuron count (1..256).
REQ-003 SHALL have parameter DW, default 16, meaning signed data width of x, w, bias and y.
REQ-004 SHALL have parameter FRAC, default 8, meaning fractional bits of x, w, bias and y.
REQ-005 SHALL have port ACLK, input, 1, meaning the single clock; all logic is rising-edge.
REQ-006 SHALL have port ARESET, input, 1, meaning asynchronous active-high reset.
REQ-007 SHALL have port start, input, 1, meaning single-cycle run request.
REQ-008 SHALL have port abort, input, 1, meaning synchronous run cancel.
REQ-009 SHALL have port relu_en, input, 1, meaning ReLU enable, sampled on accepted start.
REQ-010 SHALL have port rd_en, output, 1, meaning read strobe for the x, w and bias memories.
REQ-011 SHALL have port x_addr, output, 6, meaning input-vector index i.
REQ-012 SHALL have port w_addr, output, clog2(N_OUT*64), meaning weight index j*64+i.
REQ-013 SHALL have port b_addr, output, clog2(N_OUT) (min 1), meaning bias index j.
REQ-014 SHALL have ports x_data, w_data and b_data, input, DW each, meaning read data valid exactly 1 cycle after rd_en.
REQ-015 SHALL have port y_valid, output, 1, meaning a result is presented.
REQ-016 SHALL have port y_ready, input, 1, meaning the consumer accepts the result.
REQ-017 SHALL have port y_data, output, DW, meaning the neuron result.
REQ-018 SHALL have port y_idx, output, 8, meaning neuron index j of y_data.
REQ-019 SHALL have port busy, output, 1, meaning a run is in progress.
REQ-020 SHALL have port done, output, 1, meaning a 1-cycle pulse at run completion.

Function
REQ-021 SHALL implement the FSM IDLE -> FETCH -> DRAIN -> OUT -> (FETCH for next j | DONE) -> IDLE.
REQ-022 SHALL accept start only in IDLE, moving to FETCH with j=0, i=0 on the next cycle; start in any other state SHALL be ignored.
REQ-023 SHALL, in FETCH, assert rd_en for 64 consecutive cycles with i=0..63 and b_addr=j throughout.
REQ-024 SHALL clear the accumulator on entry to FETCH and add sign-extended x_data*w_data each cycle after rd_en (arrivals for i=0..63).
REQ-025 SHALL capture b_data in the cycle after the i=0 read.
REQ-026 SHALL use an accumulator of 2*DW+6 bits so that no intermediate overflow occurs.
REQ-027 SHALL spend exactly 1 cycle in DRAIN, during which the i=63 product is received.
REQ-028 SHALL compute the result as r = (acc + (bias <<< FRAC)) >>> FRAC (arithmetic shift, floor), saturate r to signed DW, then force it to 0 if negative and relu_en is set.
REQ-029 SHALL register y_data and y_idx=j on DRAIN->OUT.
REQ-030 SHALL assert y_valid throughout OUT, holding y_data and y_idx stable until y_valid && y_ready.
REQ-031 SHALL, on the handshake, go to FETCH for j+1 if j<N_OUT-1, else to DONE.
REQ-032 SHALL give a minimum per-neuron time of 66 cycles.
REQ-033 SHALL assert done for exactly the 1 DONE cycle, then return to IDLE.
REQ-034 SHALL hold busy high from the first FETCH cycle through the DONE cycle.
REQ-035 SHALL, with N_OUT=10 and y_ready tied high, produce done 661 cycles after the start cycle.
REQ-036 SHALL, on abort in any non-IDLE state, go to IDLE next cycle: rd_en, y_valid, busy low; no done pulse; read data in flight discarded.
REQ-037 SHALL give abort priority over a same-cycle y handshake, in which case that result is not counted.
REQ-038 SHALL wrap i from 63 to 0 only via the DRAIN/OUT path, never inside FETCH.

Reset
REQ-039 SHALL, while ARESET is high, immediately force state=IDLE, i=j=0, acc=0, rd_en=0, y_valid=0, y_data=0, y_idx=0, busy=0, done=0 and all addresses to 0.
REQ-040 SHALL, on ARESET asserted mid-run, abandon the run with no done; start SHALL be honoured on the first clock edge after release.

Verification
REQ-041 SHALL cover: x=0x0100, w=0x0100, bias=0x0080, relu_en=0 -> y_data=0x4080 for j=0..9, y_idx 0..9 in order, done at cycle 661.
REQ-042 SHALL cover: x=0x7FFF, w=0x7FFF, bias=0x7FFF -> y_data=0x7FFF (saturation); w=0x8000, x=0x7FFF -> y_data=0x8000.
REQ-043 SHALL cover: x=0x0100, w=0xFF00, bias=0 -> y_data=0xC000 with relu_en=0 and 0x0000 with relu_en=1.
REQ-044 SHALL cover: y_ready low 10 cycles at j=3 -> y_valid held, y_data/y_idx stable, rd_en low, done delayed to cycle 671.
REQ-045 SHALL cover: abort at FETCH i=20 of j=2 -> busy=0 next cycle, no done, no further y_valid; subsequent start yields REQ-041 results exactly.
REQ-046 SHALL cover: start pulsed during busy and ARESET pulsed mid-FETCH -> start ignored; all outputs 0 immediately on reset; a clean run after release.

Source files
------------

// File: rtl/fc64_seq_ctrl_if.sv
// fc64_seq_ctrl_if
//   Bus bundle for fc64_seq_ctrl: the x/w/bias memory read port and the
//   y result stream.
//   master (sequencer side): drives rd_en, x_addr, w_addr, b_addr,
//                            y_valid, y_data, y_idx; receives x_data,
//                            w_data, b_data, y_ready.
//   slave  (memory/consumer side): the mirror image.
//   Read data is expected exactly one cycle after rd_en.
interface fc64_seq_ctrl_if #(
   parameter int N_OUT = 10,
   parameter int DW    = 16
);
   localparam int WAW = $clog2(N_OUT * 64);
   localparam int BAW = (N_OUT > 1) ? $clog2(N_OUT) : 1;

   logic           rd_en;
   logic [5:0]     x_addr;
   logic [WAW-1:0] w_addr;
   logic [BAW-1:0] b_addr;
   logic [DW-1:0]  x_data;
   logic [DW-1:0]  w_data;
   logic [DW-1:0]  b_data;
   logic           y_valid;
   logic           y_ready;
   logic [DW-1:0]  y_data;
   logic [7:0]     y_idx;

   modport master (
      output rd_en, x_addr, w_addr, b_addr, y_valid, y_data, y_idx,
      input  x_data, w_data, b_data, y_ready
   );

   modport slave (
      input  rd_en, x_addr, w_addr, b_addr, y_valid, y_data, y_idx,
      output x_data, w_data, b_data, y_ready
   );
endinterface

// File: rtl/fc64_seq_ctrl.sv
// fc64_seq_ctrl
//   Sequencer for a fully-connected layer with 64 inputs per neuron.
//   For each output neuron j it streams x[i], w[j*64+i] and bias[j] from
//   external memories, accumulates the fixed-point dot product, adds the
//   bias, rescales, saturates, optionally applies ReLU and presents the
//   result on a valid/ready stream.
//   Ports:
//     ACLK     clock, rising edge
//     ARESET   asynchronous active-high reset
//     start    single-cycle run request (accepted only when idle)
//     abort    synchronous run cancel
//     relu_en  ReLU enable, sampled when start is accepted
//     busy     run in progress (first FETCH through DONE)
//     done     one-cycle pulse at run completion
//     bus      memory read port and result stream (master side)
module fc64_seq_ctrl #(
   parameter int N_IN  = 64,
   parameter int N_OUT = 10,
   parameter int DW    = 16,
   parameter int FRAC  = 8
) (
   input  logic            ACLK,
   input  logic            ARESET,
   input  logic            start,
   input  logic            abort,
   input  logic            relu_en,
   output logic            busy,
   output logic            done,
   fc64_seq_ctrl_if.master bus
);
   localparam int ACCW = 2 * DW + 6;
   localparam int WAW  = $clog2(N_OUT * 64);
   localparam int BAW  = (N_OUT > 1) ? $clog2(N_OUT) : 1;

   localparam logic [5:0] I_LAST = 6'(N_IN - 1);
   localparam logic [7:0] J_LAST = 8'(N_OUT - 1);

   localparam logic signed [ACCW-1:0] SAT_MAX = {{(ACCW-DW+1){1'b0}}, {(DW-1){1'b1}}};
   localparam logic signed [ACCW-1:0] SAT_MIN = {{(ACCW-DW+1){1'b1}}, {(DW-1){1'b0}}};

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DRAIN,
      S_OUT,
      S_DONE
   } state_t;

   state_t                 state;
   logic [7:0]             j;
   logic                   rd_d1;
   logic                   relu_q;
   logic signed [DW-1:0]   bias;
   logic signed [ACCW-1:0] acc;

   logic signed [2*DW-1:0] x_ext;
   logic signed [2*DW-1:0] w_ext;
   logic signed [2*DW-1:0] prod;
   logic signed [ACCW-1:0] acc_sum;
   logic signed [ACCW-1:0] bias_term;
   logic signed [ACCW-1:0] pre;
   logic signed [ACCW-1:0] r;
   logic [DW-1:0]          y_next;

   // acc_sum already includes the product arriving this cycle, so in DRAIN
   // it carries the i=63 term and y_next is the complete neuron result.
   always_comb begin
      x_ext     = {{DW{bus.x_data[DW-1]}}, bus.x_data};
      w_ext     = {{DW{bus.w_data[DW-1]}}, bus.w_data};
      prod      = x_ext * w_ext;
      acc_sum   = acc + {{(ACCW-2*DW){prod[2*DW-1]}}, prod};
      bias_term = {{(ACCW-DW){bias[DW-1]}}, bias} <<< FRAC;
      pre       = acc_sum + bias_term;
      r         = pre >>> FRAC;
      if (r > SAT_MAX) begin
         y_next = {1'b0, {(DW-1){1'b1}}};
      end else if (r < SAT_MIN) begin
         y_next = {1'b1, {(DW-1){1'b0}}};
      end else begin
         y_next = r[DW-1:0];
      end
      if (relu_q && y_next[DW-1]) begin
         y_next = '0;
      end
   end

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         state       <= S_IDLE;
         j           <= '0;
         rd_d1       <= 1'b0;
         relu_q      <= 1'b0;
         bias        <= '0;
         acc         <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         bus.rd_en   <= 1'b0;
         bus.x_addr  <= '0;
         bus.w_addr  <= '0;
         bus.b_addr  <= '0;
         bus.y_valid <= 1'b0;
         bus.y_data  <= '0;
         bus.y_idx   <= '0;
      end else begin
         // rd_d1 marks cycles where read data from the previous rd_en is present.
         rd_d1 <= bus.rd_en;
         if (rd_d1) begin
            acc <= acc_sum;
         end
         // b_data for the i=0 read is present while x_addr has advanced to 1.
         if (state == S_FETCH && bus.x_addr == 6'd1) begin
            bias <= bus.b_data;
         end

         if (abort && state != S_IDLE) begin
            state       <= S_IDLE;
            j           <= '0;
            rd_d1       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            bus.rd_en   <= 1'b0;
            bus.x_addr  <= '0;
            bus.w_addr  <= '0;
            bus.b_addr  <= '0;
            bus.y_valid <= 1'b0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (start) begin
                     state      <= S_FETCH;
                     j          <= '0;
                     acc        <= '0;
                     relu_q     <= relu_en;
                     busy       <= 1'b1;
                     bus.rd_en  <= 1'b1;
                     bus.x_addr <= '0;
                     bus.w_addr <= '0;
                     bus.b_addr <= '0;
                  end
               end

               S_FETCH: begin
                  if (bus.x_addr == I_LAST) begin
                     state     <= S_DRAIN;
                     bus.rd_en <= 1'b0;
                  end else begin
                     bus.x_addr <= bus.x_addr + 6'd1;
                     bus.w_addr <= bus.w_addr + WAW'(1);
                  end
               end

               S_DRAIN: begin
                  state       <= S_OUT;
                  bus.y_valid <= 1'b1;
                  bus.y_data  <= y_next;
                  bus.y_idx   <= j;
               end

               S_OUT: begin
                  if (bus.y_ready) begin
                     bus.y_valid <= 1'b0;
                     if (j == J_LAST) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                     end else begin
                        // w_addr still holds j*64+63, so +1 lands on row j+1.
                        state      <= S_FETCH;
                        j          <= j + 8'd1;
                        acc        <= '0;
                        bus.rd_en  <= 1'b1;
                        bus.x_addr <= '0;
                        bus.w_addr <= bus.w_addr + WAW'(1);
                        bus.b_addr <= bus.b_addr + BAW'(1);
                     end
                  end
               end

               S_DONE: begin
                  state      <= S_IDLE;
                  done       <= 1'b0;
                  busy       <= 1'b0;
                  j          <= '0;
                  bus.x_addr <= '0;
                  bus.w_addr <= '0;
                  bus.b_addr <= '0;
               end

               default: state <= S_IDLE;
            endcase
         end
      end
   end
endmodule
